// File: rtl/layer_compositor_if.sv
// rtl/layer_compositor_if.sv - pixel/layer bundle between the screen pipeline and the compositor
interface layer_compositor_if #(
    parameter int N_LAYERS = 64,
    parameter int IDXW     = 6
);
    logic [9:0]             iVGA_X;
    logic [8:0]             iVGA_Y;
    logic [N_LAYERS-1:0]    iLayerVal;
    logic [24*N_LAYERS-1:0] iLayerRGB;
    logic [N_LAYERS-1:0]    iMask;
    logic [1:0]             iMode;
    logic [23:0]            iBgRGB;
    logic [7:0]             oR;
    logic [7:0]             oG;
    logic [7:0]             oB;
    logic [IDXW-1:0]        oTopIdx;
    logic                   oHit;
    logic [9:0]             oVGA_X;
    logic [8:0]             oVGA_Y;

    modport master (
        output iVGA_X, iVGA_Y, iLayerVal, iLayerRGB, iMask, iMode, iBgRGB,
        input  oR, oG, oB, oTopIdx, oHit, oVGA_X, oVGA_Y
    );

    modport slave (
        input  iVGA_X, iVGA_Y, iLayerVal, iLayerRGB, iMask, iMode, iBgRGB,
        output oR, oG, oB, oTopIdx, oHit, oVGA_X, oVGA_Y
    );
endinterface

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - three-stage layer priority select and blend for the VGA pixel stream
module layer_compositor #(
    parameter int N_LAYERS    = 64,
    parameter int IDXW        = 6,
    parameter bit FRAME_LATCH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    layer_compositor_if.slave bus
);
    logic [N_LAYERS-1:0]    sh_mask;
    logic [1:0]             sh_mode;
    logic [23:0]            sh_bg;
    logic                   load;
    logic                   use_in;
    logic [N_LAYERS-1:0]    eff_mask;
    logic [1:0]             eff_mode;
    logic [23:0]            eff_bg;

    logic [N_LAYERS-1:0]    s1_act;
    logic [24*N_LAYERS-1:0] s1_rgb;
    logic [9:0]             s1_x;
    logic [8:0]             s1_y;
    logic [1:0]             s1_mode;
    logic [23:0]            s1_bg;

    logic [IDXW-1:0]        top_idx;
    logic                   top_v;
    logic                   sec_v;
    logic [23:0]            top_col;
    logic [23:0]            sec_col;

    logic [IDXW-1:0]        s2_top_idx;
    logic                   s2_top_v;
    logic                   s2_sec_v;
    logic [23:0]            s2_top_col;
    logic [23:0]            s2_sec_col;
    logic [9:0]             s2_x;
    logic [8:0]             s2_y;
    logic [1:0]             s2_mode;
    logic [23:0]            s2_bg;

    logic [23:0]            col;
    logic [7:0]             dbg;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8:1];
    endfunction

    // The (0,0) pixel sees the freshly presented config, not the stale shadow.
    assign load     = (bus.iVGA_X == 10'd0) && (bus.iVGA_Y == 9'd0);
    assign use_in   = !FRAME_LATCH || load;
    assign eff_mask = use_in ? bus.iMask  : sh_mask;
    assign eff_mode = use_in ? bus.iMode  : sh_mode;
    assign eff_bg   = use_in ? bus.iBgRGB : sh_bg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_mask <= '1;
            sh_mode <= 2'b00;
            sh_bg   <= 24'h0;
        end else if (load) begin
            sh_mask <= bus.iMask;
            sh_mode <= bus.iMode;
            sh_bg   <= bus.iBgRGB;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_act  <= '0;
            s1_rgb  <= '0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_mode <= '0;
            s1_bg   <= '0;
        end else begin
            s1_act  <= bus.iLayerVal & eff_mask;
            s1_rgb  <= bus.iLayerRGB;
            s1_x    <= bus.iVGA_X;
            s1_y    <= bus.iVGA_Y;
            s1_mode <= eff_mode;
            s1_bg   <= eff_bg;
        end
    end

    // Ascending scan: each newly found layer demotes the previous top to second place.
    always_comb begin
        top_idx = '0;
        top_v   = 1'b0;
        sec_v   = 1'b0;
        top_col = '0;
        sec_col = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            if (s1_act[k]) begin
                sec_col = top_col;
                sec_v   = top_v;
                top_col = s1_rgb[k*24 +: 24];
                top_v   = 1'b1;
                top_idx = IDXW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s2_top_idx <= '0;
            s2_top_v   <= 1'b0;
            s2_sec_v   <= 1'b0;
            s2_top_col <= '0;
            s2_sec_col <= '0;
            s2_x       <= '0;
            s2_y       <= '0;
            s2_mode    <= '0;
            s2_bg      <= '0;
        end else begin
            s2_top_idx <= top_idx;
            s2_top_v   <= top_v;
            s2_sec_v   <= sec_v;
            s2_top_col <= top_col;
            s2_sec_col <= sec_col;
            s2_x       <= s1_x;
            s2_y       <= s1_y;
            s2_mode    <= s1_mode;
            s2_bg      <= s1_bg;
        end
    end

    assign dbg = 8'(s2_top_idx) << (8 - IDXW);

    always_comb begin
        col = s2_bg;
        if (s2_top_v) begin
            case (s2_mode)
                2'b00: col = s2_top_col;
                2'b01: col = !s2_sec_v ? s2_top_col :
                             {sat_add(s2_top_col[23:16], s2_sec_col[23:16]),
                              sat_add(s2_top_col[15:8],  s2_sec_col[15:8]),
                              sat_add(s2_top_col[7:0],   s2_sec_col[7:0])};
                2'b10: col = !s2_sec_v ? s2_top_col :
                             {avg(s2_top_col[23:16], s2_sec_col[23:16]),
                              avg(s2_top_col[15:8],  s2_sec_col[15:8]),
                              avg(s2_top_col[7:0],   s2_sec_col[7:0])};
                default: col = {dbg, dbg, dbg};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.oR      <= '0;
            bus.oG      <= '0;
            bus.oB      <= '0;
            bus.oTopIdx <= '0;
            bus.oHit    <= 1'b0;
            bus.oVGA_X  <= '0;
            bus.oVGA_Y  <= '0;
        end else begin
            bus.oR      <= col[23:16];
            bus.oG      <= col[15:8];
            bus.oB      <= col[7:0];
            bus.oTopIdx <= s2_top_v ? s2_top_idx : '0;
            bus.oHit    <= s2_top_v;
            bus.oVGA_X  <= s2_x;
            bus.oVGA_Y  <= s2_y;
        end
    end
endmodule
